// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the CPU port, debug port and memory-side bus of the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic              busy;
  logic              owner;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_dout,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    output mem_we, mem_addr, mem_din, busy, owner
  );

  // Requesters plus memory side, as seen by the surrounding system.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_dout,
    input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    input  mem_we, mem_addr, mem_din, busy, owner
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of cycles the debug port has waited; flags when it must be served.
module arb_starve_cnt #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  input  logic grant_i,
  output logic starved_o
);

  localparam logic [7:0] MaxCnt = 8'(STARVE_MAX);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_i) begin
      cnt_d = '0;
    end else if (wait_i && (cnt_q < MaxCnt)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter, CPU over debug, one transaction per IDLE/ISSUE/RESP pass.
// Defining MEM_ARB_STARVE_EN adds a counter that forces a debug grant after STARVE_MAX waits.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_starve_max_check
    $error("STARVE_MAX must be in 1..255");
  end

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              starved;
  logic              pick_dbg;
  logic              cpu_ack, dbg_ack;

  assign pick_dbg = bus.dbg_req & (~bus.cpu_req | starved);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          state_d    = ISSUE;
          owner_d    = pick_dbg ? OWNER_DBG : OWNER_CPU;
          mem_we_d   = pick_dbg ? bus.dbg_we : bus.cpu_we;
          mem_addr_d = pick_dbg ? bus.dbg_addr : bus.cpu_addr;
          mem_din_d  = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        // Loaded on writes too; the value is simply don't-care then.
        if (owner_q == OWNER_DBG) begin
          dbg_rdata_d = bus.mem_dout;
        end else begin
          cpu_rdata_d = bus.mem_dout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_CPU;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

`ifdef MEM_ARB_STARVE_EN
  logic dbg_grant, dbg_wait;

  assign dbg_grant = (state_q == IDLE) & pick_dbg;
  // A debug transaction already in flight is not waiting.
  assign dbg_wait  = bus.dbg_req & ~dbg_grant & ~((state_q != IDLE) & (owner_q == OWNER_DBG));

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .wait_i   (dbg_wait),
    .grant_i  (dbg_grant),
    .starved_o(starved)
  );
`else
  assign starved = 1'b0;
`endif

  assign cpu_ack = (state_q == RESP) & (owner_q == OWNER_CPU);
  assign dbg_ack = (state_q == RESP) & (owner_q == OWNER_DBG);

  // Bypass mem_dout during the ack cycle so rdata is valid alongside ack.
  assign bus.cpu_ack   = cpu_ack;
  assign bus.dbg_ack   = dbg_ack;
  assign bus.cpu_rdata = cpu_ack ? bus.mem_dout : cpu_rdata_q;
  assign bus.dbg_rdata = dbg_ack ? bus.mem_dout : dbg_rdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized two-port run
// checked against a transaction-level memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 2;
`ifdef MEM_ARB_STARVE_EN
  localparam bit StarveOn = 1'b1;
`else
  localparam bit StarveOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(int i);
    return (i == 16) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(i));
  endfunction

  // Synchronous memory: read data valid one cycle after the address is sampled.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      bus.mem_dout <= '0;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_din;
      bus.mem_dout <= mem[bus.mem_addr[7:0]];
    end
  end

  task automatic init_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic test_reset();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    init_ref();
    #1 rst = 1'b0;
    #2;
    n_run++;
    if ({bus.busy, bus.owner, bus.mem_we, bus.cpu_ack, bus.dbg_ack} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.busy, bus.owner, bus.mem_we, bus.cpu_ack, bus.dbg_ack});
    end
    n_run++;
    if (bus.mem_addr !== '0 || bus.mem_din !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: got addr %h din %h want 0", bus.mem_addr, bus.mem_din);
    end
    n_run++;
    if (bus.cpu_rdata !== '0 || bus.dbg_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h %h want 0", bus.cpu_rdata, bus.dbg_rdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_run++;
    if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: got busy %b we %b want 0 0", bus.busy, bus.mem_we);
    end
  endtask

  task automatic test_cpu_read();
    int            lat;
    logic          we_seen;
    logic [DW-1:0] rd;
    lat = 0; we_seen = 0; rd = '0;
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10; bus.cpu_wdata = $urandom();
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (bus.mem_we) we_seen = 1;
      if (bus.cpu_ack) begin lat = c; rd = bus.cpu_rdata; end
    end
    @(negedge clk);
    bus.cpu_req = 0;
    n_run++;
    if (lat != 2) begin n_fail++; $display("FAIL cpu_read_lat: got %0d want 2", lat); end
    n_run++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL cpu_read_data: got %h want deadbeef", rd);
    end
    n_run++;
    if (we_seen !== 1'b0) begin n_fail++; $display("FAIL cpu_read_we: got 1 want 0"); end
    @(posedge clk); #1;
    n_run++;
    if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL cpu_rdata_hold: got ack %b data %h want 0 deadbeef",
               bus.cpu_ack, bus.cpu_rdata);
    end
  endtask

  task automatic test_dbg_write();
    int            lat, we_cnt;
    logic [AW-1:0] a_seen;
    logic [DW-1:0] d_seen;
    logic          own;
    lat = 0; we_cnt = 0; a_seen = '0; d_seen = '0; own = 0;
    @(negedge clk);
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h20; bus.dbg_wdata = 32'h12345678;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (bus.mem_we) begin we_cnt++; a_seen = bus.mem_addr; d_seen = bus.mem_din; end
      if (bus.dbg_ack) begin lat = c; own = bus.owner; end
    end
    @(negedge clk);
    bus.dbg_req = 0; bus.dbg_we = 0;
    @(posedge clk); #1;
    if (bus.mem_we) we_cnt++;
    ref_mem[8'h20] = 32'h12345678;
    n_run++;
    if (lat != 2) begin n_fail++; $display("FAIL dbg_write_lat: got %0d want 2", lat); end
    n_run++;
    if (we_cnt != 1) begin n_fail++; $display("FAIL dbg_write_we_cnt: got %0d want 1", we_cnt); end
    n_run++;
    if (a_seen !== 32'h20 || d_seen !== 32'h12345678) begin
      n_fail++;
      $display("FAIL dbg_write_bus: got %h/%h want 00000020/12345678", a_seen, d_seen);
    end
    n_run++;
    if (own !== OWNER_DBG) begin n_fail++; $display("FAIL dbg_write_owner: got %b want 1", own); end
  endtask

  task automatic test_simultaneous();
    int            cpu_t, dbg_t;
    logic          cpu_own, dbg_own, overlap;
    logic [DW-1:0] cpu_rd, dbg_rd;
    cpu_t = 0; dbg_t = 0; cpu_own = 1; dbg_own = 0; overlap = 0; cpu_rd = '0; dbg_rd = '0;
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h44;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h20;
    for (int c = 1; c <= 12 && (cpu_t == 0 || dbg_t == 0); c++) begin
      @(posedge clk); #1;
      if (bus.cpu_ack && bus.dbg_ack) overlap = 1;
      if (bus.cpu_ack && cpu_t == 0) begin cpu_t = c; cpu_own = bus.owner; cpu_rd = bus.cpu_rdata; end
      if (bus.dbg_ack && dbg_t == 0) begin dbg_t = c; dbg_own = bus.owner; dbg_rd = bus.dbg_rdata; end
      @(negedge clk);
      if (cpu_t != 0) bus.cpu_req = 0;
      if (dbg_t != 0) bus.dbg_req = 0;
    end
    n_run++;
    if (cpu_t != 2 || dbg_t != 5) begin
      n_fail++; $display("FAIL simul_timing: got cpu %0d dbg %0d want 2 5", cpu_t, dbg_t);
    end
    n_run++;
    if (cpu_own !== OWNER_CPU || dbg_own !== OWNER_DBG) begin
      n_fail++; $display("FAIL simul_owner_seq: got %b,%b want 0,1", cpu_own, dbg_own);
    end
    n_run++;
    if (overlap !== 1'b0) begin n_fail++; $display("FAIL simul_overlap: both acks high"); end
    n_run++;
    if (cpu_rd !== ref_mem[8'h44] || dbg_rd !== ref_mem[8'h20]) begin
      n_fail++;
      $display("FAIL simul_data: got %h %h want %h %h", cpu_rd, dbg_rd,
               ref_mem[8'h44], ref_mem[8'h20]);
    end
  endtask

  task automatic test_back_to_back();
    int            ack_t [2];
    logic [DW-1:0] rd [2];
    int            n_ack, idle_between;
    logic [DW-1:0] wd2;
    n_ack = 0; idle_between = 0; ack_t[0] = 0; ack_t[1] = 0; rd[0] = '0; rd[1] = '0;
    wd2 = $urandom();
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h05; bus.cpu_wdata = $urandom();
    for (int c = 1; c <= 12 && n_ack < 2; c++) begin
      @(posedge clk); #1;
      if (n_ack == 1 && !bus.busy) idle_between++;
      if (bus.cpu_ack) begin ack_t[n_ack] = c; rd[n_ack] = bus.cpu_rdata; n_ack++; end
      @(negedge clk);
      if (n_ack == 1) begin bus.cpu_addr = 32'h06; bus.cpu_wdata = wd2; end
      if (n_ack == 2) bus.cpu_req = 0;
    end
    n_run++;
    if (n_ack != 2 || ack_t[0] != 2 || ack_t[1] - ack_t[0] != 3) begin
      n_fail++;
      $display("FAIL b2b_timing: got %0d acks at %0d,%0d want 2 at 2,5", n_ack, ack_t[0], ack_t[1]);
    end
    n_run++;
    if (idle_between != 1) begin
      n_fail++; $display("FAIL b2b_busy_gap: got %0d want 1", idle_between);
    end
    n_run++;
    if (rd[0] !== ref_mem[8'h05] || rd[1] !== ref_mem[8'h06]) begin
      n_fail++;
      $display("FAIL b2b_data: got %h %h want %h %h", rd[0], rd[1], ref_mem[8'h05], ref_mem[8'h06]);
    end
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 32'h06 || bus.mem_din !== wd2)
    begin
      n_fail++;
      $display("FAIL idle_hold: got we %b busy %b addr %h din %h want 0 0 00000006 %h",
               bus.mem_we, bus.busy, bus.mem_addr, bus.mem_din, wd2);
    end
  endtask

  task automatic test_starvation();
    logic q_own [$];
    logic exp_own [$];
    int   waited;
    logic both;
    both = 0; waited = 0;
    // Each lost transaction costs debug three waiting cycles.
    for (int k = 0; k < 8; k++) begin
      if (StarveOn && waited >= int'(SMAX)) begin
        exp_own.push_back(OWNER_DBG); waited = 0;
      end else begin
        exp_own.push_back(OWNER_CPU); waited += 3;
      end
    end
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h07;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h08;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (bus.cpu_ack && bus.dbg_ack) both = 1;
      if (bus.cpu_ack) q_own.push_back(OWNER_CPU);
      if (bus.dbg_ack) q_own.push_back(OWNER_DBG);
    end
    @(negedge clk);
    bus.cpu_req = 0; bus.dbg_req = 0;
    n_run++;
    if (q_own.size() != 8 || both) begin
      n_fail++; $display("FAIL starve_ack_count: got %0d overlap %b want 8 0", q_own.size(), both);
    end
    for (int k = 0; k < 8 && k < q_own.size(); k++) begin
      n_run++;
      if (q_own[k] !== exp_own[k]) begin
        n_fail++; $display("FAIL starve_order[%0d]: got %b want %b", k, q_own[k], exp_own[k]);
      end
    end
  endtask

  task automatic test_random();
    logic          c_act, d_act, c_we, d_we;
    logic [7:0]    c_a, d_a;
    logic [DW-1:0] c_wd, d_wd;
    int            c_wait, d_wait;
    c_act = 0; d_act = 0; c_we = 0; d_we = 0; c_a = '0; d_a = '0; c_wd = '0; d_wd = '0;
    c_wait = 0; d_wait = 0;
    for (int cyc = 0; cyc < 360; cyc++) begin
      @(negedge clk);
      if (cyc < 300 && !c_act && $urandom_range(0, 1) == 1) begin
        c_act = 1; c_we = 1'($urandom_range(0, 1)); c_a = 8'($urandom_range(0, 255));
        c_wd = $urandom(); c_wait = 0;
      end
      if (cyc < 300 && !d_act && $urandom_range(0, 1) == 1) begin
        d_act = 1; d_we = 1'($urandom_range(0, 1)); d_a = 8'($urandom_range(0, 255));
        d_wd = $urandom(); d_wait = 0;
      end
      bus.cpu_req = c_act; bus.cpu_we = c_we; bus.cpu_addr = {24'h0, c_a}; bus.cpu_wdata = c_wd;
      bus.dbg_req = d_act; bus.dbg_we = d_we; bus.dbg_addr = {24'h0, d_a}; bus.dbg_wdata = d_wd;
      @(posedge clk); #1;
      if (bus.cpu_ack && bus.dbg_ack) begin
        n_run++; n_fail++; $display("FAIL rand_dual_ack: both acks high at cycle %0d", cyc);
      end
      if (bus.cpu_ack) begin
        n_run++;
        if (!c_act) begin
          n_fail++; $display("FAIL rand_cpu_ack: got ack want none (no request)");
        end else if (!c_we && bus.cpu_rdata !== ref_mem[c_a]) begin
          n_fail++; $display("FAIL rand_cpu_rdata: got %h want %h", bus.cpu_rdata, ref_mem[c_a]);
        end
        if (c_act && c_we) ref_mem[c_a] = c_wd;
        c_act = 0;
      end
      if (bus.dbg_ack) begin
        n_run++;
        if (!d_act) begin
          n_fail++; $display("FAIL rand_dbg_ack: got ack want none (no request)");
        end else if (!d_we && bus.dbg_rdata !== ref_mem[d_a]) begin
          n_fail++; $display("FAIL rand_dbg_rdata: got %h want %h", bus.dbg_rdata, ref_mem[d_a]);
        end
        if (d_act && d_we) ref_mem[d_a] = d_wd;
        d_act = 0;
      end
      if (c_act && ++c_wait > 100) begin
        n_run++; n_fail++; $display("FAIL rand_cpu_timeout: got no ack want ack"); c_act = 0;
      end
      if (d_act && ++d_wait > 100) begin
        n_run++; n_fail++; $display("FAIL rand_dbg_timeout: got no ack want ack"); d_act = 0;
      end
    end
    @(negedge clk);
    bus.cpu_req = 0; bus.dbg_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_issue();
    logic ack_seen;
    ack_seen = 0;
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h30; bus.cpu_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    n_run++;
    if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL issue_we: got %b want 1", bus.mem_we); end
    #2 rst = 1'b0;
    #1;
    n_run++;
    if (bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL abort_we_async: got %b want 0", bus.mem_we);
    end
    n_run++;
    if ({bus.busy, bus.owner, bus.cpu_ack, bus.dbg_ack} !== 4'b0) begin
      n_fail++;
      $display("FAIL abort_ctrl: got %b want 0000", {bus.busy, bus.owner, bus.cpu_ack, bus.dbg_ack});
    end
    n_run++;
    if (bus.mem_addr !== '0 || bus.mem_din !== '0 || bus.cpu_rdata !== '0 || bus.dbg_rdata !== '0)
    begin
      n_fail++;
      $display("FAIL abort_data: got %h %h %h %h want all 0",
               bus.mem_addr, bus.mem_din, bus.cpu_rdata, bus.dbg_rdata);
    end
    @(negedge clk);
    bus.cpu_req = 0; bus.cpu_we = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.cpu_ack) ack_seen = 1;
    end
    n_run++;
    if (ack_seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack: got ack want none"); end
    init_ref();
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_addr = 32'h10;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_run++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL first_edge_arb: got busy %b want 1", bus.busy); end
    @(posedge clk); #1;
    n_run++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== ref_mem[8'h10]) begin
      n_fail++;
      $display("FAIL post_reset_read: got ack %b data %h want 1 %h",
               bus.cpu_ack, bus.cpu_rdata, ref_mem[8'h10]);
    end
    @(negedge clk);
    bus.cpu_req = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_simultaneous();
    test_back_to_back();
    test_starvation();
    test_random();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, memory address width in bits.
REQ-002 Parameter DATA_W, 32, memory data width in bits.
REQ-003 Parameter STARVE_MAX, 8, number of debug wait cycles before a forced debug grant; legal range 1..255.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cpu_req, cpu_we  in  1 each  CPU request and write enable.
REQ-007 cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W.
REQ-008 cpu_ack  out  1; cpu_rdata  out  DATA_W.
REQ-009 dbg_req, dbg_we  in  1 each  debug/loader request and write enable.
REQ-010 dbg_addr  in  ADDR_W; dbg_wdata  in  DATA_W.
REQ-011 dbg_ack  out  1; dbg_rdata  out  DATA_W.
REQ-012 mem_we  out  1; mem_addr  out  ADDR_W; mem_din  out  DATA_W.
REQ-013 mem_dout  in  DATA_W  synchronous memory read data, valid 1 cycle after the address is sampled.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 owner  out  1  0 = CPU, 1 = debug; current or most recent grantee.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-017 The FSM SHALL advance IDLE->ISSUE on any req, ISSUE->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-018 In IDLE, the arbiter SHALL sample a request: the winner's addr, wdata and we are registered onto mem_addr, mem_din and mem_we, and owner is updated.
REQ-019 mem_we SHALL be high only during ISSUE, for exactly one cycle per write transaction.
REQ-020 In RESP, the winner's ack SHALL be high for exactly one cycle, and its rdata SHALL be loaded from mem_dout.
REQ-021 rdata SHALL hold its value until the next ack to the same requester.
REQ-022 Latency SHALL be 2 cycles from request sampled in IDLE to ack; peak throughput SHALL be one transaction per 3 cycles.
REQ-023 Requesters SHALL hold req and all request fields stable until ack.
REQ-024 A req still high in the cycle after ack SHALL be treated as a new transaction.
REQ-025 Arbitration default: on simultaneous requests, the CPU SHALL win.
REQ-026 A loser's req SHALL be unaffected by losing, and its ack SHALL stay low.
REQ-027 Write transactions SHALL also receive an ack; rdata on a write ack is don't-care but SHALL still be loaded.
REQ-028 With no req in IDLE, mem_we SHALL be 0, and mem_addr and mem_din SHALL hold their values.

Reset
REQ-029 While rst = 0, the outputs SHALL be: state IDLE, mem_we 0, mem_addr 0, mem_din 0, both acks 0, both rdata 0, busy 0, owner 0, starvation counter 0.
REQ-030 Reset asserted during ISSUE SHALL abort the transaction immediately, with mem_we dropping asynchronously and no ack issued.
REQ-031 After reset deassertion, the first arbitration SHALL occur on the first rising edge with rst = 1.

Configuration
REQ-032 With MEM_ARB_STARVE_EN defined, an 8-bit counter SHALL increment each cycle that dbg_req = 1 and debug is not granted.
REQ-033 The counter SHALL saturate at STARVE_MAX and clear on a debug grant.
REQ-034 When the counter equals STARVE_MAX, debug SHALL win the next IDLE arbitration even against cpu_req.
REQ-035 Without MEM_ARB_STARVE_EN, the counter SHALL be absent and fixed CPU priority SHALL apply.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, RESP) and the owner constants OWNER_CPU = 0 and OWNER_DBG = 1.
REQ-037 The starvation counter SHALL be a sub-module, arb_starve_cnt (inputs: wait, grant; output: starved), instantiated only under MEM_ARB_STARVE_EN.

Verification
REQ-038 CPU read: cpu_req = 1, addr 0x10, mem returns 0xDEADBEEF -> cpu_ack on cycle +2, cpu_rdata = 0xDEADBEEF, mem_we stays 0.
REQ-039 Debug write: dbg addr 0x20, wdata 0x12345678, we = 1 -> mem_we high for 1 cycle with mem_addr 0x20 and mem_din 0x12345678; dbg_ack on cycle +2.
REQ-040 Simultaneous requests, macro off -> CPU granted first; debug acked 3 cycles after the CPU ack; owner sequence 0, 1.
REQ-041 Starvation, macro on, STARVE_MAX = 2: cpu_req and dbg_req held high continuously -> debug granted at the first IDLE after its counter reaches 2; counter then reads 0.
REQ-042 Reset mid-ISSUE of a CPU write -> mem_we falls without a clock edge; no cpu_ack; all outputs at reset values.
REQ-043 Back-to-back: cpu_req held for 2 transactions -> acks 3 cycles apart; busy low for exactly one cycle between them.
